// File: rtl/onehot_stream_encoder_pkg.sv
// Shared widths and FSM state encoding for the one-hot stream encoder.
// Optional ENC_ROUND_ROBIN_EN selects round-robin scan order in the top.
package onehot_stream_encoder_pkg;

    localparam int ENC_WIDTH = 8;
    localparam int ENC_IDXW  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } enc_state_e;

endpackage

// File: rtl/onehot_stream_encoder_if.sv
// Request-vector in / bit-index out handshake bundle.
// slave is the encoder side, master is the producer/consumer side.
interface onehot_stream_encoder_if
    import onehot_stream_encoder_pkg::*;
#(
    parameter int WIDTH = ENC_WIDTH,
    parameter int IDXW  = ENC_IDXW
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
    logic             zero_err;

    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_idx,
        output out_last,
        output zero_err
    );

    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_idx,
        input  out_last,
        input  zero_err
    );

endinterface

// File: rtl/onehot_stream_encoder_bit_find.sv
// Combinational first-set-bit search starting at an offset, wrapping
// from WIDTH-1 back to 0. idx is 0 when nothing is set.
module bit_find #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [IDXW-1:0]  start,
    output logic [IDXW-1:0]  idx,
    output logic             found
);

    int j;

    // Walk from the farthest candidate back to start so the
    // last hit written is the nearest one to the offset.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            j = (int'(start) + k) % WIDTH;
            if (vec[j]) begin
                idx   = IDXW'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/onehot_stream_encoder.sv
// Sequential 8-to-3 encoder: emits the index of every set request bit.
// Define ENC_ROUND_ROBIN_EN for a persistent round-robin scan pointer.
module onehot_stream_encoder
    import onehot_stream_encoder_pkg::*;
#(
    parameter int WIDTH = ENC_WIDTH,
    parameter int IDXW  = ENC_IDXW
) (
    input logic                    clk,
    input logic                    rst,
    onehot_stream_encoder_if.slave bus
);

    enc_state_e       state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             zero_err_q, zero_err_d;
    logic [IDXW-1:0]  start;
    logic [IDXW-1:0]  sel_idx;
    logic [IDXW-1:0]  idx_inc;
    logic             sel_found;
    logic             last;
    logic             out_valid;
    logic             out_hs;

`ifdef ENC_ROUND_ROBIN_EN
    logic [IDXW-1:0]  ptr_q, ptr_d;
    assign start = ptr_q;
`else
    assign start = '0;
`endif

    bit_find #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_find (
        .vec   (pend_q),
        .start (start),
        .idx   (sel_idx),
        .found (sel_found)
    );

    assign last      = ($countones(pend_q) == 1);
    assign out_valid = (state_q == ST_SCAN) && sel_found;
    assign out_hs    = out_valid && bus.out_ready;
    assign idx_inc   = (sel_idx == IDXW'(WIDTH - 1)) ?
                       '0 : sel_idx + IDXW'(1);

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        zero_err_d = 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
        ptr_d      = ptr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (|bus.in_vec) begin
                        pend_d  = bus.in_vec;
                        state_d = ST_SCAN;
                    end else begin
                        zero_err_d = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (out_hs) begin
                    pend_d[sel_idx] = 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
                    ptr_d = idx_inc;
`endif
                    if (last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            zero_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            zero_err_q <= zero_err_d;
        end
    end

`ifdef ENC_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Pointer increment only matters in the round-robin build.
    logic unused_inc;
    assign unused_inc = ^idx_inc;
`endif

    assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
    assign bus.out_valid = out_valid;
    assign bus.out_idx   = sel_idx;
    assign bus.out_last  = out_valid && last;
    assign bus.zero_err  = zero_err_q;

endmodule

// File: tb/tb_onehot_stream_encoder.sv
// Randomized self-checking bench for onehot_stream_encoder.
// Scan order model follows ENC_ROUND_ROBIN_EN when it is defined.
module tb_onehot_stream_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    onehot_stream_encoder_if #(.WIDTH(8), .IDXW(3)) bus ();

    onehot_stream_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_pend;
    int         m_ptr;
    logic [7:0] got_acc;
    int         got_q[$];

    function automatic int m_next_idx();
        for (int k = 0; k < 8; k++) begin
            if (m_pend[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
        end
        return 0;
    endfunction

    function automatic void m_retire(input int idx);
        m_pend[idx] = 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
        m_ptr = (idx + 1) % 8;
`endif
    endfunction

    function automatic logic [7:0] dec3x8(input logic [2:0] a);
        logic [7:0] one;
        one = 8'd1;
        return one << a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        int t;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        n_checks++;
        if (t >= 50) begin
            n_errors++;
            $display("FAIL push_ready: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
        step();
        bus.in_valid = 1'b0;
        bus.in_vec   = 8'($urandom);
        m_pend  = v;
        got_acc = 8'h00;
        got_q.delete();
    endtask

    task automatic drain(input bit rnd, input int max_beats);
        int   beats;
        int   budget;
        int   e;
        logic exp_last;
        logic rdy;
        logic [2:0] seen;
        beats  = 0;
        budget = 400;
        while (m_pend != 8'h00 && beats < max_beats && budget > 0) begin
            e        = m_next_idx();
            exp_last = ($countones(m_pend) == 1);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'(e) ||
                bus.out_last !== exp_last) begin
                n_errors++;
                $display("FAIL beat: valid=%b idx=%0d last=%b required 1 %0d %b",
                         bus.out_valid, bus.out_idx, bus.out_last, e, exp_last);
            end
            seen = bus.out_idx;
            rdy  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready = rdy;
            step();
            budget--;
            if (rdy) begin
                m_retire(e);
                got_q.push_back(int'(seen));
                got_acc = got_acc | dec3x8(seen);
                beats++;
            end
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (budget == 0) begin
            n_errors++;
            $display("FAIL drain_budget: beats=%0d required completion", beats);
        end
        if (m_pend == 8'h00) begin
            n_checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL idle_after: out_valid=%b in_ready=%b required 0 1",
                         bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_idx !== 3'd0 ||
            bus.out_last !== 1'b0 || bus.zero_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: v=%b i=%0d l=%b z=%b required 0 0 0 0",
                     bus.out_valid, bus.out_idx, bus.out_last, bus.zero_err);
        end
        rst = 1'b0;
        m_pend = 8'h00;
        m_ptr  = 0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready: in_ready=%b required 1", bus.in_ready);
        end
        step();
    endtask

    task automatic test_single();
        push(8'b0000_0001);
        drain(1'b0, 99);
    endtask

    task automatic test_multi();
        int exp3[3];
        exp3 = '{0, 2, 7};
        push(8'b1000_0101);
        drain(1'b0, 99);
`ifndef ENC_ROUND_ROBIN_EN
        n_checks++;
        if (got_q.size() != 3 || got_q[0] != exp3[0] ||
            got_q[1] != exp3[1] || got_q[2] != exp3[2]) begin
            n_errors++;
            $display("FAIL multi_order: got %p required 0 2 7", got_q);
        end
`else
        n_checks++;
        if (got_acc !== 8'h85) begin
            n_errors++;
            $display("FAIL multi_set: got %02h required 85", got_acc);
        end
`endif
    endtask

    task automatic test_stall();
        int e;
        push(8'h14);
        e = m_next_idx();
        for (int c = 0; c < 3; c++) begin
            bus.out_ready = 1'b0;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'(e) ||
                bus.out_last !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_hold: v=%b i=%0d l=%b required 1 %0d 0",
                         bus.out_valid, bus.out_idx, bus.out_last, e);
            end
            step();
        end
        drain(1'b0, 99);
    endtask

    task automatic test_zero();
        push(8'h00);
        n_checks++;
        if (bus.zero_err !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL zero_pulse: z=%b v=%b r=%b required 1 0 1",
                     bus.zero_err, bus.out_valid, bus.in_ready);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++;
            if (bus.zero_err !== 1'b0 || bus.out_valid !== 1'b0 ||
                bus.in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL zero_after: z=%b v=%b r=%b required 0 0 1",
                         bus.zero_err, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_reset_scan();
        push(8'hFF);
        drain(1'b0, 3);
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_async: out_valid=%b required 0", bus.out_valid);
        end
        m_pend = 8'h00;
        m_ptr  = 0;
        step();
        #2;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL rst_stale: in_ready=%b out_valid=%b required 1 0",
                         bus.in_ready, bus.out_valid);
            end
        end
    endtask

`ifdef ENC_ROUND_ROBIN_EN
    task automatic test_round_robin();
        logic [7:0] vecs[5];
        int         seq[5][2];
        vecs = '{8'h81, 8'h81, 8'h03, 8'h03, 8'h06};
        seq  = '{'{0, 7}, '{0, 7}, '{0, 1}, '{0, 1}, '{2, 1}};
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_pend = 8'h00;
        m_ptr  = 0;
        step();
        for (int n = 0; n < 5; n++) begin
            push(vecs[n]);
            drain(1'b0, 99);
            n_checks++;
            if (got_q.size() != 2 || got_q[0] != seq[n][0] ||
                got_q[1] != seq[n][1]) begin
                n_errors++;
                $display("FAIL rr_order vec=%02h: got %p required %0d %0d",
                         vecs[n], got_q, seq[n][0], seq[n][1]);
            end
        end
    endtask
`endif

    task automatic test_loopback();
        for (int v = 1; v < 256; v++) begin
            push(8'(v));
            drain(1'b1, 99);
            n_checks++;
            if (got_acc !== 8'(v)) begin
                n_errors++;
                $display("FAIL loopback: decoded %02h required %02h", got_acc, 8'(v));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        for (int n = 0; n < 40; n++) begin
            v = 8'($urandom);
            push(v);
            if (v == 8'h00) begin
                n_checks++;
                if (bus.zero_err !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_zero: zero_err=%b required 1", bus.zero_err);
                end
            end else begin
                drain(1'b1, 99);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_vec    = 8'h00;
        bus.out_ready = 1'b0;
        m_pend  = 8'h00;
        m_ptr   = 0;
        got_acc = 8'h00;
        test_reset();
        test_single();
        test_multi();
        test_stall();
        test_zero();
        test_reset_scan();
`ifdef ENC_ROUND_ROBIN_EN
        test_round_robin();
`endif
        test_loopback();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
